taxi_pcie_rd_req_split: RTL and testbench

- Downstream consumer of the per-function max_read_req_size vector produced by the PCIe configuration shim.
- Splits each DMA read request (address, byte length, function) into PCIe-legal memory read sub-requests.
- Each sub-request is no larger than the function's Max Read Request Size (MRRS) and never crosses a 4 KB address boundary.
- Sits between the DMA read engine's descriptor path and the TLP request generator.

---
 rtl/taxi_pcie_pkg.sv | 29 ++
 rtl/taxi_pcie_chunk_calc.sv | 37 +++
 rtl/taxi_pcie_rd_req_split.sv | 171 +++++++++++++++++
 tb/tb_taxi_pcie_rd_req_split.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_pcie_pkg.sv
// ============================================================================
// Module   : taxi_pcie_pkg
// Brief    : Shared PCIe constants, size-code decode and request struct.
// Revision : 1.0
// ============================================================================
`default_nettype none

package taxi_pcie_pkg;

  localparam int PCIE_4K_BOUNDARY = 4096;

  // Device Control MRRS/MPS encoding: 0..5 -> 128<<c, 6/7 are reserved and treated as 4 KB.
  function automatic logic [12:0] pcie_size_decode(input logic [2:0] code);
    if (code > 3'd5) begin
      return 13'd4096;
    end
    return 13'd128 << code;
  endfunction

  typedef struct packed {
    logic [63:0] addr;
    logic [19:0] len;
    logic [7:0]  func;
    logic [7:0]  id;
  } pcie_req_t;

endpackage

`default_nettype wire

// File: rtl/taxi_pcie_chunk_calc.sv
// ============================================================================
// Module   : taxi_pcie_chunk_calc
// Brief    : Combinational chunk size: min(remaining, MRRS, bytes to 4 KB).
// Revision : 1.0
// ============================================================================
`default_nettype none

module taxi_pcie_chunk_calc
  import taxi_pcie_pkg::*;
#(
  parameter int LEN_W = 20
) (
  input  logic [11:0]      i_addr_lo,
  input  logic [LEN_W-1:0] i_remaining,
  input  logic [12:0]      i_mrrs_bytes,
  output logic [12:0]      o_chunk_len,
  output logic             o_chunk_last
);

  localparam int CW = (LEN_W > 13) ? LEN_W : 13;

  logic [12:0]   w_to_boundary;
  logic [12:0]   w_limit;
  logic [CW-1:0] w_rem_ext;
  logic [CW-1:0] w_limit_ext;

  assign w_to_boundary = 13'(PCIE_4K_BOUNDARY) - {1'b0, i_addr_lo};
  assign w_limit       = (i_mrrs_bytes < w_to_boundary) ? i_mrrs_bytes : w_to_boundary;
  assign w_rem_ext     = CW'(i_remaining);
  assign w_limit_ext   = CW'(w_limit);

  assign o_chunk_last  = (w_rem_ext <= w_limit_ext);
  assign o_chunk_len   = o_chunk_last ? w_rem_ext[12:0] : w_limit;

endmodule

`default_nettype wire

// File: rtl/taxi_pcie_rd_req_split.sv
// ============================================================================
// Module   : taxi_pcie_rd_req_split
// Brief    : Splits DMA reads into MRRS-sized, 4 KB-safe PCIe read requests.
//            Optional counters: define TAXI_PCIE_RD_REQ_SPLIT_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module taxi_pcie_rd_req_split
  import taxi_pcie_pkg::*;
#(
  parameter  int F_COUNT      = 1,
  parameter  int ADDR_W       = 64,
  parameter  int LEN_W        = 20,
  parameter  int ID_W         = 8,
  parameter  int MAX_REQ_SIZE = 4096,
  localparam int CL_F_COUNT   = (F_COUNT > 1) ? $clog2(F_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [F_COUNT*3-1:0]  max_read_req_size,
  input  logic [ADDR_W-1:0]     s_req_addr,
  input  logic [LEN_W-1:0]      s_req_len,
  input  logic [CL_F_COUNT-1:0] s_req_func,
  input  logic [ID_W-1:0]       s_req_id,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  output logic [ADDR_W-1:0]     m_req_addr,
  output logic [12:0]           m_req_len,
  output logic [CL_F_COUNT-1:0] m_req_func,
  output logic [ID_W-1:0]       m_req_id,
  output logic                  m_req_last,
  output logic                  m_req_valid,
  input  logic                  m_req_ready
`ifdef TAXI_PCIE_RD_REQ_SPLIT_STATS_EN
  ,
  output logic [31:0]           stat_req_count,
  output logic [31:0]           stat_sub_count
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [LEN_W-1:0]      r_rem;
  logic [12:0]           r_mrrs;
  logic [12:0]           r_len;
  logic [CL_F_COUNT-1:0] r_func;
  logic [ID_W-1:0]       r_id;
  logic                  r_last;
  logic                  r_valid;

  logic [12:0]           w_mrrs_sel;
  logic [12:0]           w_mrrs_in;
  logic [ADDR_W-1:0]     w_next_addr;
  logic [LEN_W-1:0]      w_next_rem;
  logic [11:0]           w_calc_addr;
  logic [LEN_W-1:0]      w_calc_rem;
  logic [12:0]           w_calc_mrrs;
  logic [12:0]           w_chunk;
  logic                  w_last;
  logic                  w_s_fire;
  logic                  w_m_fire;

  // Out-of-range function indices fall back to the 128-byte minimum.
  always_comb begin
    w_mrrs_sel = 13'd128;
    for (int i = 0; i < F_COUNT; i++) begin
      if (s_req_func == CL_F_COUNT'(i)) begin
        w_mrrs_sel = pcie_size_decode(max_read_req_size[i*3 +: 3]);
      end
    end
    w_mrrs_in = (w_mrrs_sel > 13'(MAX_REQ_SIZE)) ? 13'(MAX_REQ_SIZE) : w_mrrs_sel;
  end

  assign w_next_addr = r_addr + ADDR_W'(r_len);
  assign w_next_rem  = r_rem - LEN_W'(r_len);

  // One calculator serves both the first chunk (from the input) and every following one.
  assign w_calc_addr = (r_state == ST_IDLE) ? s_req_addr[11:0] : w_next_addr[11:0];
  assign w_calc_rem  = (r_state == ST_IDLE) ? s_req_len        : w_next_rem;
  assign w_calc_mrrs = (r_state == ST_IDLE) ? w_mrrs_in        : r_mrrs;

  taxi_pcie_chunk_calc #(
    .LEN_W        (LEN_W)
  ) u_chunk_calc (
    .i_addr_lo    (w_calc_addr),
    .i_remaining  (w_calc_rem),
    .i_mrrs_bytes (w_calc_mrrs),
    .o_chunk_len  (w_chunk),
    .o_chunk_last (w_last)
  );

  assign s_req_ready = (r_state == ST_IDLE);
  assign w_s_fire    = s_req_valid && s_req_ready;
  assign w_m_fire    = r_valid && m_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_mrrs  <= '0;
      r_len   <= '0;
      r_func  <= '0;
      r_id    <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_s_fire && (s_req_len != '0)) begin
            r_addr  <= s_req_addr;
            r_rem   <= s_req_len;
            r_mrrs  <= w_mrrs_in;
            r_func  <= s_req_func;
            r_id    <= s_req_id;
            r_len   <= w_chunk;
            r_last  <= w_last;
            r_valid <= 1'b1;
            r_state <= ST_SPLIT;
          end
        end
        ST_SPLIT: begin
          if (w_m_fire) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_addr <= w_next_addr;
              r_rem  <= w_next_rem;
              r_len  <= w_chunk;
              r_last <= w_last;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_req_addr  = r_addr;
  assign m_req_len   = r_len;
  assign m_req_func  = r_func;
  assign m_req_id    = r_id;
  assign m_req_last  = r_last;
  assign m_req_valid = r_valid;

`ifdef TAXI_PCIE_RD_REQ_SPLIT_STATS_EN
  logic [31:0] r_stat_req;
  logic [31:0] r_stat_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_req <= '0;
      r_stat_sub <= '0;
    end else begin
      if (w_s_fire) r_stat_req <= r_stat_req + 32'd1;
      if (w_m_fire) r_stat_sub <= r_stat_sub + 32'd1;
    end
  end

  assign stat_req_count = r_stat_req;
  assign stat_sub_count = r_stat_sub;
`endif

endmodule

`default_nettype wire

// File: tb/tb_taxi_pcie_rd_req_split.sv
// ============================================================================
// Module   : tb_taxi_pcie_rd_req_split
// Brief    : Randomized self-checking bench with a transaction-level split model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_taxi_pcie_rd_req_split;

  typedef struct packed {
    logic [63:0] addr;
    logic [12:0] len;
    logic [1:0]  func;
    logic [7:0]  id;
    logic        last;
  } sub_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  max_read_req_size = '0;
  logic [63:0] s_req_addr = '0;
  logic [19:0] s_req_len = '0;
  logic [1:0]  s_req_func = '0;
  logic [7:0]  s_req_id = '0;
  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [63:0] m_req_addr;
  logic [12:0] m_req_len;
  logic [1:0]  m_req_func;
  logic [7:0]  m_req_id;
  logic        m_req_last;
  logic        m_req_valid;
  logic        m_req_ready = 1'b0;
`ifdef TAXI_PCIE_RD_REQ_SPLIT_STATS_EN
  logic [31:0] stat_req_count;
  logic [31:0] stat_sub_count;
`endif

  int   errors = 0;
  int   checks = 0;
  int   first_wait;
  sub_t obs_q[$];
  sub_t exp_q[$];

  always #5 clk = ~clk;

  taxi_pcie_rd_req_split #(
    .F_COUNT (3), .ADDR_W (64), .LEN_W (20), .ID_W (8), .MAX_REQ_SIZE (4096)
  ) dut (
    .clk (clk), .rst (rst), .max_read_req_size (max_read_req_size),
    .s_req_addr (s_req_addr), .s_req_len (s_req_len), .s_req_func (s_req_func),
    .s_req_id (s_req_id), .s_req_valid (s_req_valid), .s_req_ready (s_req_ready),
    .m_req_addr (m_req_addr), .m_req_len (m_req_len), .m_req_func (m_req_func),
    .m_req_id (m_req_id), .m_req_last (m_req_last), .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready)
`ifdef TAXI_PCIE_RD_REQ_SPLIT_STATS_EN
    , .stat_req_count (stat_req_count), .stat_sub_count (stat_sub_count)
`endif
  );

  function automatic int unsigned ref_mrrs(input logic [8:0] codes, input logic [1:0] f);
    logic [2:0] c;
    if (f > 2'd2) return 128;
    c = codes[f*3 +: 3];
    if (c > 3'd5) return 4096;
    return 128 << c;
  endfunction

  // Reference: walk the byte range, cutting at MRRS and at every 4 KB line.
  task automatic build_exp(input logic [63:0] a, input int unsigned l, input logic [8:0] codes,
                           input logic [1:0] f, input logic [7:0] id);
    int unsigned rem, mb, c, room;
    logic [63:0] cur;
    sub_t e;
    exp_q.delete();
    mb = ref_mrrs(codes, f);
    rem = l;
    cur = a;
    while (rem > 0) begin
      room = 4096 - 32'(cur[11:0]);
      c = rem;
      if (mb < c) c = mb;
      if (room < c) c = room;
      e.addr = cur; e.len = 13'(c); e.func = f; e.id = id; e.last = (c == rem);
      exp_q.push_back(e);
      cur = cur + 64'(c);
      rem = rem - c;
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [19:0] l, input logic [1:0] f,
                       input logic [7:0] id);
    int n;
    @(negedge clk);
    s_req_addr = a; s_req_len = l; s_req_func = f; s_req_id = id; s_req_valid = 1'b1;
    n = 0;
    while (!s_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 s_req_valid = 1'b0;
  endtask

  task automatic collect(input int ready_pct);
    sub_t o;
    int cyc;
    bit done;
    done = 0; cyc = 0; first_wait = -1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      m_req_ready = ($urandom_range(99) < ready_pct);
      if (m_req_valid && first_wait < 0) first_wait = cyc;
      if (m_req_valid && m_req_ready) begin
        o.addr = m_req_addr; o.len = m_req_len; o.func = m_req_func;
        o.id = m_req_id; o.last = m_req_last;
        obs_q.push_back(o);
        if (m_req_last) done = 1;
      end
      cyc++;
    end
    @(posedge clk);
    #1 m_req_ready = 1'b0;
  endtask

  task automatic run_req(input logic [63:0] a, input logic [19:0] l, input logic [1:0] f,
                         input logic [7:0] id, input int ready_pct);
    build_exp(a, 32'(l), max_read_req_size, f, id);
    obs_q.delete();
    issue(a, l, f, id);
    collect(ready_pct);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (s_req_ready !== 1'b1 || m_req_valid !== 1'b0 || m_req_last !== 1'b0 ||
        m_req_addr !== '0 || m_req_len !== '0 || m_req_func !== '0 || m_req_id !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b last=%b addr=%h len=%0d func=%0d id=%h, required 1 0 0 0 0 0 0",
               s_req_ready, m_req_valid, m_req_last, m_req_addr, m_req_len, m_req_func, m_req_id);
    end
`ifdef TAXI_PCIE_RD_REQ_SPLIT_STATS_EN
    checks++;
    if (stat_req_count !== 0 || stat_sub_count !== 0) begin
      errors++;
      $display("FAIL reset_stats: req=%0d sub=%0d, required 0 0", stat_req_count, stat_sub_count);
    end
`endif
  endtask

  task automatic test_mrrs512();
    max_read_req_size = {3'd2, 3'd2, 3'd2};
    run_req(64'h1000, 20'd1500, 2'd0, 8'h5A, 100);
    checks++;
    if (first_wait !== 0) begin
      errors++;
      $display("FAIL mrrs512_latency: first valid after %0d cycles, required 0", first_wait);
    end
    checks++;
    if (exp_q.size() != 3 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mrrs512_count: got %0d chunks, required 3 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mrrs512_chunk%0d: got addr=%h len=%0d last=%b, required addr=%h len=%0d last=%b",
                 i, obs_q[i].addr, obs_q[i].len, obs_q[i].last, exp_q[i].addr, exp_q[i].len, exp_q[i].last);
      end
    end
  endtask

  task automatic test_4k_cross();
    max_read_req_size = {3'd5, 3'd5, 3'd5};
    run_req(64'h0FF0, 20'd64, 2'd1, 8'h11, 100);
    checks++;
    if (obs_q.size() != 2 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL cross4k_count: got %0d chunks, required 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL cross4k_chunk%0d: got addr=%h len=%0d last=%b, required addr=%h len=%0d last=%b",
                 i, obs_q[i].addr, obs_q[i].len, obs_q[i].last, exp_q[i].addr, exp_q[i].len, exp_q[i].last);
      end
    end
  endtask

  task automatic test_max_chunk();
    max_read_req_size = {3'd7, 3'd7, 3'd7};
    run_req(64'h0, 20'd8192, 2'd2, 8'h77, 100);
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL max4096_count: got %0d chunks, required 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].len !== 13'h1000) begin
        errors++;
        $display("FAIL max4096_chunk%0d: got addr=%h len=%h last=%b, required addr=%h len=1000 last=%b",
                 i, obs_q[i].addr, obs_q[i].len, obs_q[i].last, exp_q[i].addr, exp_q[i].last);
      end
    end
  endtask

  task automatic test_zero_len();
    int bad;
`ifdef TAXI_PCIE_RD_REQ_SPLIT_STATS_EN
    logic [31:0] before;
    before = stat_req_count;
`endif
    issue(64'h2000, 20'd0, 2'd0, 8'h01);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_req_valid !== 1'b0 || s_req_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_len: %0d cycles with valid=1 or ready=0, required 0", bad);
    end
`ifdef TAXI_PCIE_RD_REQ_SPLIT_STATS_EN
    checks++;
    if (stat_req_count !== before + 32'd1) begin
      errors++;
      $display("FAIL zero_len_stat: req_count=%0d, required %0d", stat_req_count, before + 32'd1);
    end
`endif
  endtask

  task automatic test_stall();
    sub_t snap, cur;
    int moved;
    max_read_req_size = {3'd5, 3'd0, 3'd5};
    build_exp(64'h3000_0100, 32'd1024, max_read_req_size, 2'd1, 8'hC3);
    obs_q.delete();
    issue(64'h3000_0100, 20'd1024, 2'd1, 8'hC3);
    @(negedge clk);
    m_req_ready = 1'b1;
    snap.addr = m_req_addr; snap.len = m_req_len; snap.func = m_req_func;
    snap.id = m_req_id; snap.last = m_req_last;
    if (m_req_valid) obs_q.push_back(snap);
    @(negedge clk);
    m_req_ready = 1'b0;
    snap.addr = m_req_addr; snap.len = m_req_len; snap.func = m_req_func;
    snap.id = m_req_id; snap.last = m_req_last;
    max_read_req_size = {3'd5, 3'd5, 3'd5};
    moved = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cur.addr = m_req_addr; cur.len = m_req_len; cur.func = m_req_func;
      cur.id = m_req_id; cur.last = m_req_last;
      if (cur !== snap || m_req_valid !== 1'b1) moved++;
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL stall_stable: outputs changed in %0d of 5 stalled cycles, required 0", moved);
    end
    collect(100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d chunks, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_chunk%0d: got addr=%h len=%0d last=%b, required addr=%h len=%0d last=%b",
                 i, obs_q[i].addr, obs_q[i].len, obs_q[i].last, exp_q[i].addr, exp_q[i].len, exp_q[i].last);
      end
    end
  endtask

  task automatic test_reset_mid();
    max_read_req_size = {3'd0, 3'd0, 3'd0};
    issue(64'h4000, 20'd1024, 2'd0, 8'h22);
    @(negedge clk);
    m_req_ready = 1'b1;
    @(negedge clk);
    m_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_req_valid !== 1'b0 || s_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b ready=%b, required valid=0 ready=1", m_req_valid, s_req_ready);
    end
    rst = 1'b0;
    max_read_req_size = {3'd1, 3'd1, 3'd1};
    run_req(64'h5F80, 20'd700, 2'd0, 8'h33, 100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d chunks, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_chunk%0d: got addr=%h len=%0d last=%b, required addr=%h len=%0d last=%b",
                 i, obs_q[i].addr, obs_q[i].len, obs_q[i].last, exp_q[i].addr, exp_q[i].len, exp_q[i].last);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [19:0] l;
    logic [1:0]  f;
    for (int n = 0; n < 24; n++) begin
      max_read_req_size = 9'($urandom);
      f = 2'($urandom_range(3));
      if (n == 0) begin
        a = 64'hFFFF_FFFF_FFFF_FF80; l = 20'd256;
      end else begin
        a = {$urandom, $urandom};
        if (n % 3 == 0) a[11:0] = 12'hFFF - 12'($urandom_range(63));
        l = 20'($urandom_range(5000, 1));
      end
      run_req(a, l, f, 8'(n), int'($urandom_range(100, 30)));
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL random%0d_count: got %0d chunks, required %0d", n, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random%0d_chunk%0d: got %h, required %h", n, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_mrrs512();
    test_4k_cross();
    test_max_chunk();
    test_zero_len();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
